// File: rtl/uart_pkg.sv
// Shared UART constants and transmitter state encoding.
package uart_pkg;
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;
endpackage

// File: rtl/uart_tx_if.sv
// Byte write port of the UART transmitter: push handshake plus fill level.
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int FIFO_AW = 4
);
   logic                      wrEn;
   logic [UART_DATA_BITS-1:0] wrData;
   logic                      wrReady;
   logic [FIFO_AW:0]          level;

   modport master (output wrEn, wrData, input wrReady, level);
   modport slave  (input wrEn, wrData, output wrReady, level);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; dout shows the head entry whenever the FIFO is non-empty.
module uart_tx_fifo #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [DW-1:0] mem_q [2**AW];
   logic [AW-1:0] wrPtr_q, rdPtr_q;
   logic [AW:0]   count_q;
   logic          doPush, doPop;

   // A push while full is dropped even if a pop happens in the same cycle.
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         case ({doPush, doPop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem_q[wrPtr_q] <= din;
   end

   assign dout  = mem_q[rdPtr_q];
   assign count = count_q;
   assign full  = (count_q == DEPTH);
   assign empty = (count_q == '0);
endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter paced by a 16x-baud strobe, fed from a byte FIFO.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FIFO_AW   = 4,
   parameter int STOP_BITS = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      baudEn,
   uart_tx_if.slave  wr,
   output logic      busy,
   output logic      txd
);
   tx_state_e                 state_q, state_d;
   logic [3:0]                ph_q, ph_d;
   logic [2:0]                bitnum_q, bitnum_d;
   logic                      stopCnt_q, stopCnt_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      txd_q, txd_d;
   logic                      pop;
   logic [UART_DATA_BITS-1:0] fifoDout;
   logic                      fifoFull, fifoEmpty;
   logic [FIFO_AW:0]          fifoCount;

   uart_tx_fifo #(.AW(FIFO_AW), .DW(UART_DATA_BITS)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr.wrEn),
      .din   (wr.wrData),
      .pop   (pop),
      .dout  (fifoDout),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .count (fifoCount)
   );

   assign wr.wrReady = ~fifoFull;
   assign wr.level   = fifoCount;

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      bitnum_d  = bitnum_q;
      stopCnt_d = stopCnt_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      pop       = 1'b0;
      if (baudEn) begin
         case (state_q)
            TX_IDLE: if (!fifoEmpty) begin
               pop     = 1'b1;
               shift_d = fifoDout;
               txd_d   = 1'b0;
               ph_d    = 4'hF;
               state_d = TX_START;
            end
            TX_START: if (ph_q == 4'd0) begin
               txd_d    = shift_q[0];
               bitnum_d = 3'd0;
               ph_d     = 4'hF;
               state_d  = TX_DATA;
            end else ph_d = ph_q - 4'd1;
            TX_DATA: if (ph_q == 4'd0) begin
               ph_d = 4'hF;
               if (bitnum_q == 3'd7) begin
                  txd_d     = 1'b1;
                  stopCnt_d = 1'(STOP_BITS - 1);
                  state_d   = TX_STOP;
               end else begin
                  shift_d  = shift_q >> 1;
                  txd_d    = shift_q[1];
                  bitnum_d = bitnum_q + 3'd1;
               end
            end else ph_d = ph_q - 4'd1;
            TX_STOP: if (ph_q == 4'd0) begin
               if (stopCnt_q != 1'b0) begin
                  stopCnt_d = 1'b0;
                  ph_d      = 4'hF;
               end else if (!fifoEmpty) begin
                  // Next frame's start bit begins on the same tick: no idle gap.
                  pop     = 1'b1;
                  shift_d = fifoDout;
                  txd_d   = 1'b0;
                  ph_d    = 4'hF;
                  state_d = TX_START;
               end else state_d = TX_IDLE;
            end else ph_d = ph_q - 4'd1;
            default: begin
               state_d = TX_IDLE;
               txd_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= TX_IDLE;
         ph_q      <= '0;
         bitnum_q  <= '0;
         stopCnt_q <= 1'b0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         ph_q      <= ph_d;
         bitnum_q  <= bitnum_d;
         stopCnt_q <= stopCnt_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
      end
   end

   assign txd  = txd_q;
   assign busy = (state_q != TX_IDLE) | ~fifoEmpty;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-tick line capture compared against frames built from the queued bytes.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        baudRun = 1'b0;
   logic [31:0] cyc = '0;
   logic        baudEn;
   logic        busyA, txdA, busyB, txdB;

   uart_tx_if #(.FIFO_AW(AW)) ifA ();
   uart_tx_if #(.FIFO_AW(AW)) ifB ();

   uart_tx #(.FIFO_AW(AW), .STOP_BITS(1)) dutA (
      .clk(clk), .rst_n(rst_n), .baudEn(baudEn), .wr(ifA.slave), .busy(busyA), .txd(txdA));
   uart_tx #(.FIFO_AW(AW), .STOP_BITS(2)) dutB (
      .clk(clk), .rst_n(rst_n), .baudEn(baudEn), .wr(ifB.slave), .busy(busyB), .txd(txdB));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign baudEn = baudRun && (cyc[1:0] == 2'd3);

   // Line value after every baudEn edge, one entry per 16x tick.
   bit tA[$], tB[$];
   bit pend = 1'b0;
   initial forever begin
      @(negedge clk);
      if (pend) begin
         tA.push_back(txdA);
         tB.push_back(txdB);
      end
      pend = baudEn;
   end

   int nvec = 0, nbad = 0;
   logic [7:0] expq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input bit useB, input logic [7:0] d);
      if (useB) begin ifB.wrEn = 1'b1; ifB.wrData = d; end
      else begin ifA.wrEn = 1'b1; ifA.wrData = d; end
      @(negedge clk);
      ifA.wrEn = 1'b0;
      ifB.wrEn = 1'b0;
   endtask

   task automatic wait_idle(input bit useB, input string nm);
      int n = 0;
      while ((useB ? busyB : busyA) && n < 20000) begin @(negedge clk); n++; end
      chk({nm, "_drain"}, useB ? busyB : busyA, 0);
      repeat (80) @(negedge clk);
   endtask

   task automatic wait_baud(input string nm);
      int n = 0;
      while (!baudEn && n < 8) begin @(negedge clk); n++; end
      chk({nm, "_baud"}, baudEn, 1);
   endtask

   // Expected line per frame: 16 ticks low, 8 data bits LSB first at 16 ticks each, S*16 ticks high.
   task automatic check_stream(input bit useB, input int S, input bit contig, input string nm);
      bit tk[$];
      int j = 0;
      int flen = UART_OVERSAMPLE * (UART_DATA_BITS + 1 + S);
      bit ok, eb;
      logic [7:0] got;
      if (useB) tk = tB; else tk = tA;
      for (int f = 0; f < expq.size(); f++) begin
         if (!(contig && f > 0))
            while (j < tk.size() && tk[j] == 1'b1) j++;
         ok  = (j + flen <= tk.size());
         got = 'x;
         if (ok) begin
            for (int t = 0; t < flen; t++) begin
               if (t < 16) eb = 1'b0;
               else if (t < 144) eb = expq[f][(t - 16) / 16];
               else eb = 1'b1;
               if (tk[j + t] != eb) ok = 1'b0;
            end
            for (int b = 0; b < 8; b++) got[b] = tk[j + 16 * (b + 1) + 8];
         end
         chk($sformatf("%s_frame%0d", nm, f), {23'd0, ok, got}, {23'd0, 1'b1, expq[f]});
         j += flen;
      end
      ok = 1'b1;
      for (int k = j; k < tk.size(); k++) if (tk[k] != 1'b1) ok = 1'b0;
      chk({nm, "_idle_after"}, ok, 1);
   endtask

   typedef struct {
      logic [7:0] data;
      logic [4:0] expLevel;
      logic       expReady;
   } fill_vec_t;
   fill_vec_t tbl[DEPTH + 1];

   initial begin
      logic [7:0] r;
      logic [4:0] lvl;
      ifA.wrEn = 1'b0; ifA.wrData = '0;
      ifB.wrEn = 1'b0; ifB.wrData = '0;
      for (int i = 0; i <= DEPTH; i++) begin
         tbl[i].data     = 8'h30 + 8'(i * 7);
         tbl[i].expLevel = (i + 1 < DEPTH) ? 5'(i + 1) : 5'(DEPTH);
         tbl[i].expReady = (i + 1 < DEPTH);
      end

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_txdA", txdA, 1);   chk("rst_busyA", busyA, 0);
      chk("rst_readyA", ifA.wrReady, 1); chk("rst_levelA", ifA.level, 0);
      chk("rst_txdB", txdB, 1);   chk("rst_busyB", busyB, 0);
      chk("rst_readyB", ifB.wrReady, 1); chk("rst_levelB", ifB.level, 0);

      // Single frame 0xA5 and busy release timing
      baudRun = 1'b1;
      tA.delete();
      push(0, 8'hA5);
      wait_baud("t1");
      repeat (640) @(negedge clk);
      chk("t1_busy_last_tick", busyA, 1);
      @(negedge clk);
      chk("t1_busy_after", busyA, 0);
      chk("t1_txd_after", txdA, 1);
      repeat (40) @(negedge clk);
      expq = '{8'hA5};
      check_stream(0, 1, 1'b1, "t1");

      // Back-to-back frames
      tA.delete();
      push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
      wait_idle(0, "t2");
      expq = '{8'h00, 8'hFF, 8'h55};
      check_stream(0, 1, 1'b1, "t2");

      // Fill past full with the baud strobe held off
      baudRun = 1'b0;
      tA.delete();
      expq.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         push(0, tbl[i].data);
         chk($sformatf("t3_level%0d", i), ifA.level, tbl[i].expLevel);
         chk($sformatf("t3_ready%0d", i), ifA.wrReady, tbl[i].expReady);
         if (i < DEPTH) expq.push_back(tbl[i].data);
      end
      baudRun = 1'b1;
      wait_idle(0, "t3");
      check_stream(0, 1, 1'b1, "t3");

      // Push on the exact cycle of the second frame's pop
      baudRun = 1'b0;
      tA.delete();
      push(0, 8'h5A); push(0, 8'hC3);
      baudRun = 1'b1;
      wait_baud("t4");
      repeat (640) @(negedge clk);
      ifA.wrEn = 1'b1; ifA.wrData = 8'h96;
      lvl = ifA.level;
      chk("t4_level_before", lvl, 1);
      @(negedge clk);
      ifA.wrEn = 1'b0;
      chk("t4_level_after", ifA.level, 1);
      wait_idle(0, "t4");
      expq = '{8'h5A, 8'hC3, 8'h96};
      check_stream(0, 1, 1'b1, "t4");

      // Two stop bits
      tB.delete();
      push(1, 8'h3C); push(1, 8'hC3);
      wait_idle(1, "t5");
      expq = '{8'h3C, 8'hC3};
      check_stream(1, 2, 1'b1, "t5");

      // Random bytes with random gaps against the queue model
      tA.delete();
      expq.delete();
      for (int k = 0; k < 10; k++) begin
         r = 8'($urandom);
         push(0, r);
         expq.push_back(r);
         repeat ($urandom_range(0, 700)) @(negedge clk);
      end
      wait_idle(0, "rnd");
      check_stream(0, 1, 1'b0, "rnd");

      // Asynchronous reset in the middle of data bit 3
      baudRun = 1'b0;
      push(0, 8'h00); push(0, 8'h11); push(0, 8'h22);
      baudRun = 1'b1;
      wait_baud("t6");
      repeat (280) @(negedge clk);
      chk("t6_bit3_low", txdA, 0);
      #2 rst_n = 1'b0;
      #1 chk("t6_async_txd", txdA, 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_level", ifA.level, 0);
      chk("t6_busy", busyA, 0);
      chk("t6_txd", txdA, 1);
      chk("t6_ready", ifA.wrReady, 1);
      tA.delete();
      repeat (800) @(negedge clk);
      expq.delete();
      check_stream(0, 1, 1'b0, "t6");

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, vectors %0d", nvec);
      $fatal(1);
   end
endmodule
